// File: rtl/lpf_step_sequencer.sv
// rtl/lpf_step_sequencer.sv - step/ramp sequencer for low-pass filter rise-time characterisation
//
// Purpose: drives a DAC code into a first-order low-pass filter. Each run applies one
// ramped step of 2^rise_shift cycles, times how long the comparator on the filter output
// takes to report settled, then discharges the filter back to zero before going idle.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         begin a run (sampled only when idle)
//   abort         terminate a run (ignored when idle, no effect while discharging)
//   target        final step code, latched on start
//   rise_shift    log2 of the ramp length, latched on start
//   cmp_in        filter output above threshold, synchronous to clk
//   dac_code      registered DAC code
//   busy          high whenever not idle
//   done          one-cycle pulse when discharge completes
//   timeout_flag  last run timed out while settling
//   aborted       last run was aborted
//   settle_cnt    cycles from start to settled, all ones on timeout/abort
module lpf_step_sequencer #(
  parameter int CODE_W      = 10,
  parameter int SHIFT_W     = 4,
  parameter int CNT_W       = 16,
  parameter int SETTLE_HOLD = 4,
  parameter int TIMEOUT     = 4000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [CODE_W-1:0]  target,
  input  logic [SHIFT_W-1:0] rise_shift,
  input  logic               cmp_in,
  output logic [CODE_W-1:0]  dac_code,
  output logic               busy,
  output logic               done,
  output logic               timeout_flag,
  output logic               aborted,
  output logic [CNT_W-1:0]   settle_cnt
);

  localparam int KW = 1 << SHIFT_W;
  localparam int PW = CODE_W + KW;
  localparam logic [CNT_W-1:0] HOLD_N    = CNT_W'(SETTLE_HOLD);
  localparam logic [CNT_W-1:0] TIMEOUT_N = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_RAMP, S_SETTLE, S_DISCHARGE} state_t;

  state_t             state_q, state_d;
  logic [CODE_W-1:0]  target_q, target_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [KW-1:0]      k_q, k_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic [CODE_W-1:0]  dac_q, dac_d;
  logic [CNT_W-1:0]   settle_q, settle_d;
  logic               tflag_q, tflag_d;
  logic               abort_q, abort_d;
  logic               done_q, done_d;

  logic [PW-1:0]      prod;
  logic [PW-1:0]      scaled;
  logic [CODE_W-1:0]  ramp_code;
  logic               k_last;
  logic [CNT_W-1:0]   cnt_inc;
  logic [CNT_W-1:0]   hold_nxt;

  // Ramp point k of 2^shift: target*k/2^shift, computed at full width so no bits are lost.
  assign prod      = PW'(target_q) * PW'(k_q);
  assign scaled    = prod >> shift_q;
  assign ramp_code = (scaled > PW'(target_q)) ? target_q : scaled[CODE_W-1:0];
  assign k_last    = (k_q == (KW'(1) << shift_q));
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    shift_d  = shift_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    dac_d    = dac_q;
    settle_d = settle_q;
    tflag_d  = tflag_q;
    abort_d  = abort_q;
    done_d   = 1'b0;
    hold_nxt = '0;

    case (state_q)
      S_IDLE: begin
        dac_d = '0;
        if (start) begin
          target_d = target;
          shift_d  = rise_shift;
          tflag_d  = 1'b0;
          abort_d  = 1'b0;
          k_d      = KW'(1);
          cnt_d    = '0;
          hold_d   = '0;
          state_d  = S_RAMP;
        end
      end

      S_RAMP: begin
        if (abort) begin
          abort_d  = 1'b1;
          settle_d = '1;
          dac_d    = '0;
          cnt_d    = '0;
          hold_d   = '0;
          state_d  = S_DISCHARGE;
        end else begin
          cnt_d = cnt_inc;
          k_d   = k_q + KW'(1);
          if (k_last) begin
            dac_d   = target_q;
            state_d = S_SETTLE;
          end else begin
            dac_d = ramp_code;
          end
        end
      end

      S_SETTLE: begin
        if (abort) begin
          abort_d  = 1'b1;
          settle_d = '1;
          dac_d    = '0;
          cnt_d    = '0;
          hold_d   = '0;
          state_d  = S_DISCHARGE;
        end else begin
          hold_nxt = cmp_in ? hold_q + CNT_W'(1) : '0;
          cnt_d    = cnt_inc;
          hold_d   = hold_nxt;
          // Settling is checked first so it wins over a same-cycle timeout.
          if (hold_nxt == HOLD_N) begin
            settle_d = cnt_inc;
            dac_d    = '0;
            cnt_d    = '0;
            hold_d   = '0;
            state_d  = S_DISCHARGE;
          end else if (cnt_inc >= TIMEOUT_N) begin
            tflag_d  = 1'b1;
            settle_d = '1;
            dac_d    = '0;
            cnt_d    = '0;
            hold_d   = '0;
            state_d  = S_DISCHARGE;
          end
        end
      end

      S_DISCHARGE: begin
        dac_d    = '0;
        hold_nxt = cmp_in ? '0 : hold_q + CNT_W'(1);
        cnt_d    = cnt_inc;
        hold_d   = hold_nxt;
        // A discharge timeout ends the run quietly; it does not flag timeout.
        if (hold_nxt == HOLD_N || cnt_inc >= TIMEOUT_N) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      target_q <= '0;
      shift_q  <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
      dac_q    <= '0;
      settle_q <= '0;
      tflag_q  <= 1'b0;
      abort_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      shift_q  <= shift_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      dac_q    <= dac_d;
      settle_q <= settle_d;
      tflag_q  <= tflag_d;
      abort_q  <= abort_d;
      done_q   <= done_d;
    end
  end

  assign dac_code     = dac_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign timeout_flag = tflag_q;
  assign aborted      = abort_q;
  assign settle_cnt   = settle_q;

endmodule

// File: tb/tb_lpf_step_sequencer.sv
// tb/tb_lpf_step_sequencer.sv - self-checking bench for lpf_step_sequencer
module tb_lpf_step_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [9:0]  target;
  logic [3:0]  rise_shift;
  logic        cmp_in;
  logic [9:0]  dac_code;
  logic        busy;
  logic        done;
  logic        timeout_flag;
  logic        aborted;
  logic [15:0] settle_cnt;

  int errors = 0;
  int checks = 0;
  logic [9:0] exp_q[$];
  logic [9:0] exp_code;
  logic [1:0] exp_bd;

  always #5 clk = ~clk;

  lpf_step_sequencer #(
    .CODE_W(10), .SHIFT_W(4), .CNT_W(16), .SETTLE_HOLD(4), .TIMEOUT(4000)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .target(target),
    .rise_shift(rise_shift), .cmp_in(cmp_in), .dac_code(dac_code), .busy(busy),
    .done(done), .timeout_flag(timeout_flag), .aborted(aborted), .settle_cnt(settle_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives one start pulse and pushes the expected ramp codes onto the scoreboard.
  task automatic start_run(input logic [9:0] t, input logic [3:0] s);
    int n;
    n = 1 << s;
    target = t;
    rise_shift = s;
    start = 1'b1;
    for (int k = 1; k <= n; k++)
      exp_q.push_back((k == n) ? t : 10'((int'(t) * k) >> s));
    tick;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; abort = 1'b0; cmp_in = 1'b0; target = '0; rise_shift = '0;
    tick; tick;
    checks++;
    if ({dac_code, busy, done, timeout_flag, aborted, settle_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_state got dac=%0d busy=%b done=%b tf=%b ab=%b sc=%0d exp all 0",
               dac_code, busy, done, timeout_flag, aborted, settle_cnt);
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_ramped_step;
    cmp_in = 1'b1;
    start_run(10'd800, 4'd2);
    checks++;
    if (busy !== 1'b1 || dac_code !== 10'd0) begin
      errors++; $display("FAIL ramp_start got busy=%b dac=%0d exp busy=1 dac=0", busy, dac_code);
    end
    for (int i = 1; i <= 4; i++) begin
      tick;
      exp_code = exp_q.pop_front();
      checks++;
      if (dac_code !== exp_code) begin
        errors++; $display("FAIL ramp_code cnt=%0d got %0d exp %0d", i, dac_code, exp_code);
      end
    end
    for (int i = 5; i <= 7; i++) begin
      tick;
      checks++;
      if (dac_code !== 10'd800 || busy !== 1'b1) begin
        errors++; $display("FAIL ramp_settling cnt=%0d got dac=%0d busy=%b exp 800/1", i, dac_code, busy);
      end
    end
    tick;
    checks++;
    if (settle_cnt !== 16'd8 || dac_code !== 10'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL ramp_settle_cnt got sc=%0d dac=%0d busy=%b exp 8/0/1", settle_cnt, dac_code, busy);
    end
    cmp_in = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick;
      exp_bd = (i < 4) ? 2'b10 : (i == 4) ? 2'b01 : 2'b00;
      checks++;
      if ({busy, done} !== exp_bd) begin
        errors++; $display("FAIL ramp_discharge cyc=%0d got busy/done=%b exp %b", i, {busy, done}, exp_bd);
      end
    end
  endtask

  task automatic test_glitch;
    int pat[7] = '{1, 1, 0, 1, 1, 1, 1};
    cmp_in = 1'b0;
    start_run(10'd500, 4'd1);
    for (int i = 1; i <= 2; i++) begin
      tick;
      exp_code = exp_q.pop_front();
      checks++;
      if (dac_code !== exp_code) begin
        errors++; $display("FAIL glitch_ramp cnt=%0d got %0d exp %0d", i, dac_code, exp_code);
      end
    end
    for (int i = 0; i < 7; i++) begin
      cmp_in = pat[i][0];
      tick;
      if (i == 5) begin
        checks++;
        if (dac_code !== 10'd500) begin
          errors++; $display("FAIL glitch_early_settle got dac=%0d exp 500", dac_code);
        end
      end
    end
    checks++;
    if (settle_cnt !== 16'd9 || dac_code !== 10'd0) begin
      errors++; $display("FAIL glitch_settle_cnt got sc=%0d dac=%0d exp 9/0", settle_cnt, dac_code);
    end
    cmp_in = 1'b0;
    for (int i = 1; i <= 4; i++) tick;
    checks++;
    if ({busy, done} !== 2'b01) begin
      errors++; $display("FAIL glitch_done got busy/done=%b exp 01", {busy, done});
    end
  endtask

  task automatic test_timeout;
    int n;
    cmp_in = 1'b0;
    start_run(10'd300, 4'd2);
    for (int i = 1; i <= 4; i++) begin
      tick;
      exp_code = exp_q.pop_front();
      checks++;
      if (dac_code !== exp_code) begin
        errors++; $display("FAIL timeout_ramp cnt=%0d got %0d exp %0d", i, dac_code, exp_code);
      end
    end
    n = 4;
    while (timeout_flag !== 1'b1 && n < 4100) begin
      tick;
      n++;
    end
    checks++;
    if (n !== 4000) begin
      errors++; $display("FAIL timeout_cycle got %0d exp 4000", n);
    end
    checks++;
    if (settle_cnt !== 16'hFFFF || aborted !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL timeout_result got sc=%h ab=%b busy=%b exp ffff/0/1", settle_cnt, aborted, busy);
    end
    for (int i = 1; i <= 5; i++) begin
      tick;
      exp_bd = (i < 4) ? 2'b10 : (i == 4) ? 2'b01 : 2'b00;
      checks++;
      if ({busy, done} !== exp_bd) begin
        errors++; $display("FAIL timeout_discharge cyc=%0d got busy/done=%b exp %b", i, {busy, done}, exp_bd);
      end
    end
    checks++;
    if (timeout_flag !== 1'b1 || settle_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL timeout_hold got tf=%b sc=%h exp 1/ffff", timeout_flag, settle_cnt);
    end
  endtask

  task automatic test_abort;
    cmp_in = 1'b0;
    start_run(10'd800, 4'd3);
    tick;
    exp_code = exp_q.pop_front();
    checks++;
    if (dac_code !== exp_code) begin
      errors++; $display("FAIL abort_ramp1 got %0d exp %0d", dac_code, exp_code);
    end
    exp_q.delete();
    abort = 1'b1; start = 1'b1; target = 10'd5;
    tick;
    abort = 1'b0; start = 1'b0;
    checks++;
    if (dac_code !== 10'd0 || aborted !== 1'b1 || settle_cnt !== 16'hFFFF || timeout_flag !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL abort_result got dac=%0d ab=%b sc=%h tf=%b busy=%b exp 0/1/ffff/0/1",
                         dac_code, aborted, settle_cnt, timeout_flag, busy);
    end
    for (int i = 1; i <= 5; i++) begin
      tick;
      exp_bd = (i < 4) ? 2'b10 : (i == 4) ? 2'b01 : 2'b00;
      checks++;
      if ({busy, done} !== exp_bd) begin
        errors++; $display("FAIL abort_discharge cyc=%0d got busy/done=%b exp %b", i, {busy, done}, exp_bd);
      end
    end
  endtask

  task automatic test_reset_midrun;
    cmp_in = 1'b1;
    start_run(10'd600, 4'd2);
    for (int i = 0; i < 6; i++) tick;
    exp_q.delete();
    rst = 1'b1;
    tick;
    checks++;
    if ({dac_code, busy, done, timeout_flag, aborted, settle_cnt} !== '0) begin
      errors++;
      $display("FAIL midrun_reset got dac=%0d busy=%b done=%b tf=%b ab=%b sc=%0d exp all 0",
               dac_code, busy, done, timeout_flag, aborted, settle_cnt);
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_ideal_step;
    cmp_in = 1'b1;
    start_run(10'd1023, 4'd0);
    tick;
    exp_code = exp_q.pop_front();
    checks++;
    if (dac_code !== exp_code) begin
      errors++; $display("FAIL ideal_code got %0d exp %0d", dac_code, exp_code);
    end
    for (int i = 0; i < 4; i++) tick;
    checks++;
    if (settle_cnt !== 16'd5 || aborted !== 1'b0 || timeout_flag !== 1'b0) begin
      errors++; $display("FAIL ideal_settle got sc=%0d ab=%b tf=%b exp 5/0/0", settle_cnt, aborted, timeout_flag);
    end
    cmp_in = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick;
      exp_bd = (i < 4) ? 2'b10 : (i == 4) ? 2'b01 : 2'b00;
      checks++;
      if ({busy, done} !== exp_bd) begin
        errors++; $display("FAIL ideal_discharge cyc=%0d got busy/done=%b exp %b", i, {busy, done}, exp_bd);
      end
    end
  endtask

  initial begin
    test_reset;
    test_ramped_step;
    test_glitch;
    test_timeout;
    test_abort;
    test_reset_midrun;
    test_ideal_step;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
